// File: rtl/keypad_pkg.sv
// Shared types, defaults and helpers for the keypad scanner and its key queue.
package keypad_pkg;

    localparam int DEF_ROWS            = 4;
    localparam int DEF_COLS            = 4;
    localparam int DEF_SCAN_CYCLES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FIFO_DEPTH      = 4;
    localparam int DEF_REPEAT_CYCLES   = 8;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Linear key number: keys are numbered row-major across the matrix.
    function automatic int unsigned key_code(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Synchronous key-code FIFO with occupancy count and a sticky overflow flag.
// A push into a full queue succeeds only if a pop happens in the same clock.
module keypad_key_fifo
    import keypad_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_clr_overflow,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage write port.
    // NOTE: the storage array has no reset; the count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a dropped push sets it, and setting beats a same-clock clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (i_push && w_full && !w_do_pop) begin
            r_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/keypad_scan_queue.sv
// Keypad matrix scanner with press/release debounce feeding a key-code FIFO.
// Optional build macro: KEYPAD_AUTO_REPEAT_EN enables auto-repeat while a key is held.
module keypad_scan_queue
    import keypad_pkg::*;
#(
    parameter  int ROWS            = DEF_ROWS,
    parameter  int COLS            = DEF_COLS,
    parameter  int SCAN_CYCLES     = DEF_SCAN_CYCLES,
    parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter  int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter  int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    localparam int KEY_W           = $clog2(ROWS * COLS),
    localparam int CNT_W           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [ROWS-1:0]  RowIn,
    output logic [COLS-1:0]  ColOut,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    input  logic             key_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic             busy
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int DW_W  = $clog2(SCAN_CYCLES + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    // Elaboration-time sanity check on the configuration.
    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_CYCLES < 1 ||
        DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("keypad_scan_queue: parameter out of range");
    end

    scan_state_t      r_state;
    logic [COL_W-1:0] r_col;
    logic [COLS-1:0]  r_col_out;
    logic [DW_W-1:0]  r_dwell;
    logic [DB_W-1:0]  r_cnt;
    logic [ROW_W-1:0] r_row;
    logic             r_busy;

    logic             w_any_low;
    logic [ROW_W-1:0] w_low_row;
    logic             w_row_low;
    logic [COL_W-1:0] w_next_col;
    logic [COLS-1:0]  w_strobe_next;
    logic             w_dwell_done;
    logic             w_db_done;
    logic             w_push_first;
    logic             w_push_rep;
    logic             w_push;
    logic [KEY_W-1:0] w_push_code;

    assign w_any_low     = ~&RowIn;
    assign w_row_low     = !RowIn[r_row];
    assign w_next_col    = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
    assign w_strobe_next = ~(COLS'(1) << w_next_col);
    assign w_dwell_done  = (r_dwell == DW_W'(SCAN_CYCLES - 1));
    assign w_db_done     = (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_push_first  = (r_state == DEBOUNCE) && w_row_low && w_db_done;
    assign w_push        = w_push_first || w_push_rep;
    assign w_push_code   = KEY_W'(keypad_pkg::key_code(32'(r_row), 32'(r_col), COLS));

    // Priority pick of the lowest-index active (low) row.
    // NOTE: default assignment first so every path assigns the output and no latch is inferred.
    always_comb begin
        w_low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!RowIn[i]) w_low_row = ROW_W'(i);
        end
    end

    // Scanner FSM: column dwell, press debounce, release debounce; registered strobe and busy.
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= SCAN;
            r_col     <= '0;
            r_col_out <= ~COLS'(1);
            r_dwell   <= '0;
            r_cnt     <= '0;
            r_row     <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (w_dwell_done) begin
                        r_dwell <= '0;
                        if (w_any_low) begin
                            r_row   <= w_low_row;
                            r_cnt   <= '0;
                            r_state <= DEBOUNCE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_col     <= w_next_col;
                            r_col_out <= w_strobe_next;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!w_row_low) begin
                        r_state   <= SCAN;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_col     <= w_next_col;
                        r_col_out <= w_strobe_next;
                    end else if (w_db_done) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_row_low) begin
                        r_cnt <= '0;
                    end else if (w_db_done) begin
                        r_state   <= SCAN;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_col     <= w_next_col;
                        r_col_out <= w_strobe_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= SCAN;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

    logic [RP_W-1:0] r_rep;

    assign w_push_rep = (r_state == HELD) && w_row_low &&
                        (r_rep == RP_W'(REPEAT_CYCLES - 1));

    // Repeat interval counter: runs while the held row stays low, clears on any high sample.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_rep <= '0;
        end else if (r_state != HELD || !w_row_low || w_push_rep) begin
            r_rep <= '0;
        end else begin
            r_rep <= r_rep + 1'b1;
        end
    end
`else
    assign w_push_rep = 1'b0;
`endif

    keypad_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk            (clk),
        .rst            (RST),
        .i_push         (w_push),
        .i_push_data    (w_push_code),
        .i_pop          (key_ready),
        .i_clr_overflow (clr_overflow),
        .o_head         (key_code),
        .o_valid        (key_valid),
        .o_count        (fifo_count),
        .o_overflow     (overflow)
    );

    assign ColOut = r_col_out;
    assign busy   = r_busy;

endmodule

// File: tb/tb_keypad_scan_queue.sv
// Directed bench for keypad_scan_queue at default parameters, with a keypad matrix model.
module tb_keypad_scan_queue;

    logic       clk = 1'b0;
    logic       RST;
    logic [3:0] RowIn;
    logic [3:0] ColOut;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_overflow;
    logic       busy;

    logic [3:0][3:0] pressed;   // pressed[row][col]

    int n_tests = 0;
    int n_fail  = 0;

    keypad_scan_queue dut (
        .clk          (clk),
        .RST          (RST),
        .RowIn        (RowIn),
        .ColOut       (ColOut),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Matrix model: a row reads low when a pressed key in it sits on a strobed column.
    always_comb begin
        RowIn = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(pressed[r] & ~ColOut)) RowIn[r] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_busy(input logic val, input string tag);
        int i = 0;
        while (busy !== val && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(tag, busy, val);
    endtask

    // Press, hold through the press debounce, release, and wait for the scanner to resume.
    task automatic press_key(input int r, input int c, input string tag);
        pressed[r][c] = 1'b1;
        wait_busy(1'b1, {tag, "_busy_rise"});
        repeat (6) @(negedge clk);
        pressed[r][c] = 1'b0;
        wait_busy(1'b0, {tag, "_busy_fall"});
    endtask

    int pops;
    logic [3:0] last_code;
    int exp_pops;
    int exp_rep;
    int guard;

    initial begin
        RST          = 1'b1;
        key_ready    = 1'b0;
        clr_overflow = 1'b0;
        pressed      = '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
        exp_pops = 3;
        exp_rep  = 4;
`else
        exp_pops = 1;
        exp_rep  = 1;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_colout",     ColOut,     4'b1110);
        check("rst_key_valid",  key_valid,  1'b0);
        check("rst_key_code",   key_code,   4'h0);
        check("rst_fifo_count", fifo_count, 3'd0);
        check("rst_overflow",   overflow,   1'b0);
        check("rst_busy",       busy,       1'b0);
        RST = 1'b0;
        @(negedge clk);
        check("scan_dwell_col0", ColOut, 4'b1110);
        @(negedge clk);
        check("scan_adv_col1", ColOut, 4'b1101);

        // 1: key 6 held with consumer ready
        key_ready = 1'b1;
        pops = 0;
        last_code = 4'hF;
        pressed[1][2] = 1'b1;
        wait_busy(1'b1, "t1_busy_rise");
        for (int i = 0; i < 20; i++) begin
            if (key_valid && key_ready) begin
                pops++;
                last_code = key_code;
            end
            @(negedge clk);
            check("t1_colout_frozen", ColOut, 4'b1011);
        end
        pressed[1][2] = 1'b0;
        guard = 0;
        while (busy && guard < 50) begin
            if (key_valid && key_ready) begin
                pops++;
                last_code = key_code;
            end
            @(negedge clk);
            guard++;
        end
        check("t1_busy_fall", busy, 1'b0);
        check("t1_pops", pops, exp_pops);
        check("t1_code", last_code, 4'd6);
        check("t1_fifo_count", fifo_count, 3'd0);
        check("t1_next_col", ColOut, 4'b0111);

        // 2: short press (2 debounce clocks) is rejected
        pressed[1][2] = 1'b1;
        wait_busy(1'b1, "t2_busy_rise");
        repeat (2) @(negedge clk);
        pressed[1][2] = 1'b0;
        @(negedge clk);
        check("t2_busy", busy, 1'b0);
        check("t2_colout", ColOut, 4'b0111);
        check("t2_fifo_count", fifo_count, 3'd0);
        check("t2_key_valid", key_valid, 1'b0);

        // 3: five presses into a depth-4 queue with consumer stalled
        key_ready = 1'b0;
        press_key(0, 0, "t3_k0");
        press_key(1, 1, "t3_k5");
        press_key(2, 2, "t3_k10");
        press_key(3, 3, "t3_k15");
        check("t3_count_full", fifo_count, 3'd4);
        check("t3_no_overflow_yet", overflow, 1'b0);
        press_key(0, 3, "t3_k3");
        check("t3_count_still_full", fifo_count, 3'd4);
        check("t3_overflow_set", overflow, 1'b1);
        key_ready = 1'b1;
        check("t3_pop0", key_code, 4'd0);
        @(negedge clk);
        check("t3_pop1", key_code, 4'd5);
        @(negedge clk);
        check("t3_pop2", key_code, 4'd10);
        @(negedge clk);
        check("t3_pop3", key_code, 4'd15);
        @(negedge clk);
        check("t3_empty_valid", key_valid, 1'b0);
        check("t3_empty_count", fifo_count, 3'd0);
        check("t3_empty_code", key_code, 4'd0);
        key_ready = 1'b0;
        check("t3_overflow_sticky", overflow, 1'b1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("t3_overflow_clr", overflow, 1'b0);

        // 4: rows 0 and 2 low on column 1 -> lowest row wins
        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        wait_busy(1'b1, "t4_busy_rise");
        repeat (6) @(negedge clk);
        pressed = '0;
        wait_busy(1'b0, "t4_busy_fall");
        check("t4_count", fifo_count, 3'd1);
        check("t4_code", key_code, 4'd1);

        // 5: reset during debounce discards queue and scanner state
        pressed[3][2] = 1'b1;
        wait_busy(1'b1, "t5_busy_rise");
        @(negedge clk);
        RST = 1'b1;
        #1;
        check("t5_colout", ColOut, 4'b1110);
        check("t5_key_valid", key_valid, 1'b0);
        check("t5_fifo_count", fifo_count, 3'd0);
        check("t5_busy", busy, 1'b0);
        pressed = '0;
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_scan_resumes", ColOut, 4'b1101);

        // 6: key 9 held 30 clocks past first push
        pressed[2][1] = 1'b1;
        guard = 0;
        while (fifo_count != 3'd1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("t6_first_push", fifo_count, 3'd1);
        repeat (30) @(negedge clk);
        check("t6_count", fifo_count, exp_rep);
        check("t6_code", key_code, 4'd9);
        pressed = '0;
        wait_busy(1'b0, "t6_busy_fall");
        key_ready = 1'b1;
        guard = 0;
        while (fifo_count != 3'd0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("t6_drained", fifo_count, 3'd0);
        check("t6_no_overflow", overflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_scan_queue.md
Name: keypad_scan_queue

Overview:
Parametrised successor to the calculator's fixed 4x4 keypad front end. Drives active-low column strobes, samples active-low rows, debounces press and release, and queues key codes in a small FIFO. A valid/ready port feeds the consumer (gencon-style controller), so keys pressed while the controller is busy are not lost. Sits between the keypad pins and the input controller.

Parameters:
ROWS, 4, number of keypad rows (2..8)
COLS, 4, number of keypad columns (2..8)
SCAN_CYCLES, 2, clocks each column is held during scanning (>=1)
DEBOUNCE_CYCLES, 4, consecutive stable clocks required for press and for release (>=1)
FIFO_DEPTH, 4, key-code queue depth (power of two, >=2)
REPEAT_CYCLES, 8, auto-repeat interval; used only with the optional feature
Derived: KEY_W = $clog2(ROWS*COLS), CNT_W = $clog2(FIFO_DEPTH+1)

Ports:
clk  in  1  system clock
RST  in  1  asynchronous, active-high reset
RowIn  in  ROWS  keypad rows, active low
ColOut  out  COLS  column strobe, active-low one-hot
key_valid  out  1  queue head valid
key_code  out  KEY_W  head code = row*COLS + col
key_ready  in  1  consumer accepts head
fifo_count  out  CNT_W  entries queued
overflow  out  1  sticky: press dropped because queue full
clr_overflow  in  1  synchronous clear of overflow
busy  out  1  high when FSM is not in SCAN

Behaviour:
- Reset (async, RST=1): state SCAN, column 0 active (ColOut = ~1), dwell counter 0, queue empty, key_valid=0, key_code=0, fifo_count=0, overflow=0, busy=0. Reset mid-press discards everything; the key must be released and pressed again.
- SCAN: hold current column for SCAN_CYCLES clocks. On the last dwell clock sample RowIn. If any bit is low, latch the lowest-index low row and the current column, then go to DEBOUNCE with the counter cleared. Otherwise advance the column (COLS-1 wraps to 0).
- DEBOUNCE: column frozen. Each clock the latched row is low, counter++. Row high at any point: go back to SCAN at the next column with no push. When the counter reaches DEBOUNCE_CYCLES: push the code, go to HELD.
- HELD: column frozen. Requires DEBOUNCE_CYCLES consecutive clocks with the latched row high; any low clock restarts that count. Then go to SCAN at the next column. Other keys are ignored while in DEBOUNCE or HELD.
- Latency: for a key that is stably low from the sample clock t, key_valid rises in clock t+DEBOUNCE_CYCLES+1 when the queue was empty.
- Queue: first-in first-out. key_valid = !empty; key_code = head (0 when empty). Pop happens when key_valid && key_ready.
- Push while full with no pop: the push is dropped and overflow is set.
- Push while full with a pop in the same clock: both succeed and fifo_count is unchanged.
- Push into an empty queue: the entry is visible the next clock; no same-cycle bypass.
- clr_overflow in the same clock as a new overflow event: set wins.
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Optional Feature:
KEYPAD_AUTO_REPEAT_EN
- Defined: in HELD, while the latched row stays low, re-push the same code every REPEAT_CYCLES clocks, counted from the initial push. Overflow rules apply to repeats. The repeat counter clears on any high sample.
- Undefined: exactly one push per debounced press, and REPEAT_CYCLES is ignored.

Decomposition:
- Package keypad_pkg:
  - scan_state_t enum {SCAN, DEBOUNCE, HELD}
  - key_code function (row, col, COLS)
  - default parameter constants
- Sub-module keypad_key_fifo: parametrised sync FIFO with count and overflow outputs, instantiated once. Scanner FSM and debounce counters stay in the top.

Test Plan:
1. Defaults. Press key 6 (row1/col2), hold 20 clocks, key_ready=1 -> ColOut frozen at 4'b1011; exactly one pop with code 6; fifo_count returns to 0.
2. Row1 low for 2 clocks in col2 (< DEBOUNCE_CYCLES) -> no push; scanning resumes at col3 (ColOut=4'b0111).
3. Five distinct presses (codes 0,5,10,15,3) with key_ready=0 -> fifo_count=4, overflow=1. Then key_ready=1 -> pops 0,5,10,15; clr_overflow -> overflow=0.
4. Rows 0 and 2 both low with col1 active -> single code 1 queued.
5. Assert RST during DEBOUNCE -> immediately ColOut=4'b1110, key_valid=0, fifo_count=0, busy=0.
6. With KEYPAD_AUTO_REPEAT_EN, REPEAT_CYCLES=8, key 9 held 30 clocks past first push -> 4 entries of code 9 queued (1 initial + 3 repeats). Without the macro -> 1 entry.
